// File: rtl/channel_reduce_pkg.sv
// Shared definitions for the streaming channel reducer: operator encodings and FSM states.
package channel_reduce_pkg;

    localparam int OP_ADD = 0;
    localparam int OP_MAX = 1;
    localparam int OP_MIN = 2;
    localparam int OP_XOR = 3;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        ACC  = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/channel_reduce_n_alu.sv
// Combinational fold operator: combines the running accumulator with one popped word.
module reduce_alu
    import channel_reduce_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP    = OP_ADD
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y,
    output logic             o_carry
);

    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};

    // Select the operator; ties in MAX/MIN keep the accumulator operand
    always_comb begin
        o_y     = i_a;
        o_carry = 1'b0;
        case (OP)
            OP_ADD: begin
                o_y     = w_sum[WIDTH-1:0];
                o_carry = w_sum[WIDTH];
            end
            OP_MAX: begin
                if (i_b > i_a) o_y = i_b;
                else           o_y = i_a;
            end
            OP_MIN: begin
                if (i_b < i_a) o_y = i_b;
                else           o_y = i_a;
            end
            OP_XOR: begin
                o_y = i_a ^ i_b;
            end
            default: begin
                o_y     = i_a;
                o_carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/channel_reduce_n.sv
// Streaming reducer: pops COUNT words from channel "in", folds them, pushes one result to "out".
module channel_reduce_n
    import channel_reduce_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int COUNT      = 4,
    parameter int OP         = OP_ADD,
    parameter int CONTINUOUS = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             valid,
    output logic             overflow,
    output logic [WIDTH-1:0] in_in_data,
    output logic             in_read_valid,
    output logic             in_rst,
    output logic             in_write_valid,
    input  logic [WIDTH-1:0] in_out_data,
    input  logic             in_read_ready,
    input  logic             in_write_ready,
    output logic [WIDTH-1:0] out_in_data,
    output logic             out_read_valid,
    output logic             out_rst,
    output logic             out_write_valid,
    input  logic [WIDTH-1:0] out_out_data,
    input  logic             out_read_ready,
    input  logic             out_write_ready
);

    localparam int                CNT_W    = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            r_state;
    logic [WIDTH-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_overflow;
    logic              r_valid;
    logic              r_out_wv;
    logic [WIDTH-1:0]  w_fold;
    logic              w_carry;
    logic              w_unused;

    reduce_alu #(
        .WIDTH (WIDTH),
        .OP    (OP)
    ) u_alu (
        .i_a     (r_acc),
        .i_b     (in_out_data),
        .o_y     (w_fold),
        .o_carry (w_carry)
    );

    // The pop request follows channel readiness directly so a word can leave in the REQ cycle;
    // it is gated by rst so every output reads 0 while reset is held.
    assign in_read_valid   = (r_state == REQ) && in_read_ready && !rst;
    assign valid           = r_valid;
    assign overflow        = r_overflow;
    assign out_in_data     = r_acc;
    assign out_write_valid = r_out_wv;
    assign in_in_data      = {WIDTH{1'b0}};
    assign in_rst          = 1'b0;
    assign in_write_valid  = 1'b0;
    assign out_read_valid  = 1'b0;
    assign out_rst         = 1'b0;
    assign w_unused        = in_write_ready ^ out_read_ready ^ (^out_out_data);

    // Reduction FSM: request a word, fold it, push the result, then pulse or latch valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= REQ;
            r_acc      <= {WIDTH{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_out_wv   <= 1'b0;
        end else begin
            case (r_state)
                REQ: begin
                    if (in_read_ready) r_state <= ACC;
                    else               r_state <= REQ;
                end
                ACC: begin
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_acc      <= in_out_data;
                        r_overflow <= 1'b0;
                    end else begin
                        r_acc      <= w_fold;
                        r_overflow <= r_overflow | w_carry;
                    end
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_state  <= WR;
                        r_out_wv <= 1'b1;
                    end else begin
                        r_state <= REQ;
                    end
                end
                WR: begin
                    if (out_write_ready) begin
                        r_out_wv <= 1'b0;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_state <= WR;
                    end
                end
                DONE: begin
                    if (CONTINUOUS != 0) begin
                        r_valid <= 1'b0;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= REQ;
                    end else begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_channel_reduce_n.sv
// Scoreboard bench: several reducer configurations driven by random channel readiness, checked
// against sums/max/min/xor computed over each issued word group.
module tb_channel_reduce_n;

    localparam int N_INST = 7;

    // Configuration table: width, words per result, operator, continuous mode
    function automatic int cfg_w(int g);
        case (g)
            1:       return 8;
            6:       return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_cnt(int g);
        case (g)
            0:       return 4;
            1:       return 2;
            5:       return 4;
            6:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int cfg_op(int g);
        case (g)
            2:       return 1;
            3:       return 2;
            4:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_cont(int g);
        if (g == 5) return 0;
        else        return 1;
    endfunction

    // Directed words for the first groups, random (sometimes tiny, to force ties) otherwise
    function automatic longint pick(int g, int k, int i, longint mask);
        longint r;
        if (k == 0 && g == 0) return longint'(i + 1);
        if (k == 0 && g == 1) return (i == 0) ? 64'd200 : 64'd100;
        if (k == 1 && g == 1) return 64'd1;
        if (k == 0 && (g == 2 || g == 3)) begin
            if (i == 0)      return 64'd7;
            else if (i == 1) return 64'hFFFF_FFFF;
            else             return 64'd3;
        end
        if (k == 0 && g == 4) begin
            if (i == 0)      return 64'hF0;
            else if (i == 1) return 64'h0F;
            else             return 64'hFF;
        end
        r = longint'({$urandom(), $urandom()}) & mask;
        if ($urandom_range(0, 3) == 0) r = longint'($urandom_range(0, 3));
        return r;
    endfunction

    logic clk;
    int   errors = 0;
    int   checks = 0;
    int   n_done = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp, input int inst);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s inst=%0d actual=0x%0h required=0x%0h", name, inst, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < N_INST; g++) begin : g_inst
        localparam int W   = cfg_w(g);
        localparam int C   = cfg_cnt(g);
        localparam int OPG = cfg_op(g);
        localparam int CT  = cfg_cont(g);

        logic         rst;
        logic         valid, overflow;
        logic [W-1:0] in_in_data, in_out_data, out_in_data, out_out_data;
        logic         in_read_valid, in_rst, in_write_valid, in_read_ready, in_write_ready;
        logic         out_read_valid, out_rst, out_write_valid, out_read_ready, out_write_ready;

        logic [W-1:0] feed[$];
        logic [W-1:0] sb_data[$];
        bit           sb_ovf[$];
        int           stall_cnt;

        channel_reduce_n #(
            .WIDTH      (W),
            .COUNT      (C),
            .OP         (OPG),
            .CONTINUOUS (CT)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .valid           (valid),
            .overflow        (overflow),
            .in_in_data      (in_in_data),
            .in_read_valid   (in_read_valid),
            .in_rst          (in_rst),
            .in_write_valid  (in_write_valid),
            .in_out_data     (in_out_data),
            .in_read_ready   (in_read_ready),
            .in_write_ready  (in_write_ready),
            .out_in_data     (out_in_data),
            .out_read_valid  (out_read_valid),
            .out_rst         (out_rst),
            .out_write_valid (out_write_valid),
            .out_out_data    (out_out_data),
            .out_read_ready  (out_read_ready),
            .out_write_ready (out_write_ready)
        );

        // One clock of the channel models: serve a pop one cycle late, re-randomise readiness
        task automatic tick();
            bit           popped;
            logic [W-1:0] word;
            @(negedge clk);
            popped = in_read_valid && in_read_ready;
            word   = W'($urandom());
            if (popped && feed.size() != 0) word = feed.pop_front();
            @(posedge clk);
            #1;
            in_out_data   = word;
            out_out_data  = W'($urandom());
            in_read_ready = (feed.size() != 0) && ($urandom_range(0, 2) != 0);
            if (stall_cnt > 0) begin
                out_write_ready = 1'b0;
                stall_cnt--;
            end else begin
                out_write_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) == 0) stall_cnt = 5;
            end
        endtask

        // Issue one word group and, if a result is due, queue the reference answer
        task automatic run_group(input int k, input int nw, input bit expect_res);
            longint mask, x, sum, mx, mn, xr;
            mask = (longint'(1) << W) - 1;
            sum = 0; mx = 0; mn = mask; xr = 0;
            for (int i = 0; i < nw; i++) begin
                x = pick(g, k, i, mask);
                feed.push_back(W'(x));
                sum += x;
                if (x > mx) mx = x;
                if (x < mn) mn = x;
                xr ^= x;
            end
            if (expect_res) begin
                case (OPG)
                    1:       sb_data.push_back(W'(mx));
                    2:       sb_data.push_back(W'(mn));
                    3:       sb_data.push_back(W'(xr));
                    default: sb_data.push_back(W'(sum & mask));
                endcase
                sb_ovf.push_back((OPG == 0) && ((sum >> W) != 0));
            end
        endtask

        initial begin
            int ng, rk;
            rst = 1'b1;
            in_read_ready = 1'b0; in_write_ready = 1'b0; out_read_ready = 1'b0;
            out_write_ready = 1'b0; in_out_data = '0; out_out_data = '0; stall_cnt = 0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            ng = (CT != 0) ? 10 : 2;
            rk = (C < 2) ? -1 : ((CT != 0) ? 2 : 0);
            for (int k = 0; k < ng; k++) begin
                if (k == rk) begin
                    run_group(k, C / 2, 1'b0);
                    for (int c = 0; c < 200 && feed.size() != 0; c++) tick();
                    chk(feed.size() == 0, "partial_pops", feed.size(), 0, g);
                    tick();
                    tick();
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                end else begin
                    run_group(k, C, 1'b1);
                    for (int c = 0; c < 400 && (feed.size() != 0 || sb_data.size() != 0); c++) tick();
                    chk(feed.size() == 0 && sb_data.size() == 0, "result_drained", sb_data.size(), 0, g);
                end
            end
            // A further group: consumed in continuous mode, left untouched once a one-shot is done
            run_group(ng, C, CT != 0);
            for (int c = 0; c < 400 && (sb_data.size() != 0 || (CT != 0 && feed.size() != 0)); c++) tick();
            repeat (30) tick();
            chk(feed.size() == ((CT != 0) ? 0 : C) && sb_data.size() == 0, "final_feed",
                feed.size(), (CT != 0) ? 0 : C, g);
            n_done++;
        end

        // Monitor: protocol rules every cycle, scoreboard compare on every push
        initial begin
            bit           prev_stall, prev_push, done_l, push, exp_valid, exp_ovf;
            logic [W-1:0] prev_data, exp_data;
            prev_stall = 1'b0; prev_push = 1'b0; done_l = 1'b0; prev_data = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    chk(!valid && !overflow && !out_write_valid && !in_read_valid && out_in_data == '0 &&
                        in_in_data == '0 && !in_rst && !in_write_valid && !out_read_valid && !out_rst,
                        "reset_outputs", {valid, overflow, out_write_valid, in_read_valid}, 0, g);
                    prev_stall = 1'b0; prev_push = 1'b0; done_l = 1'b0;
                end else begin
                    push = out_write_valid && out_write_ready;
                    if (!in_read_ready) chk(!in_read_valid, "pop_while_empty", in_read_valid, 0, g);
                    if (prev_stall)
                        chk(out_write_valid && out_in_data == prev_data && !in_read_valid, "wr_hold",
                            longint'(out_in_data), longint'(prev_data), g);
                    exp_valid = (CT != 0) ? prev_push : done_l;
                    chk(valid == exp_valid, "valid_flag", valid, exp_valid, g);
                    if (push) begin
                        chk(sb_data.size() != 0, "push_expected", sb_data.size(), 1, g);
                        if (sb_data.size() != 0) begin
                            exp_data = sb_data.pop_front();
                            exp_ovf  = sb_ovf.pop_front();
                            chk(out_in_data == exp_data, "result_data", longint'(out_in_data), longint'(exp_data), g);
                            chk(overflow == exp_ovf, "overflow", overflow, exp_ovf, g);
                        end
                    end
                    prev_stall = out_write_valid && !out_write_ready;
                    prev_data  = out_in_data;
                    prev_push  = push;
                    if (push) done_l = 1'b1;
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < 60000 && n_done < N_INST; c++) @(posedge clk);
        chk(n_done == N_INST, "instances_finished", n_done, N_INST, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
